// File: rtl/base_mem_fifo_ctl.sv
// FIFO controller for an external registered-read dual-port memory, with a
// two-entry output buffer so a full-rate stream survives the read latency.
module base_mem_fifo_ctl #(
  parameter int width      = 1,
  parameter int addr_width = 1,
  parameter int depth      = 2**addr_width,
  parameter int wdelay     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [width-1:0]      i_d,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [width-1:0]      o_d,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_wa,
  output logic [width-1:0]      mem_wd,
  output logic                  mem_re,
  output logic [addr_width-1:0] mem_ra,
  input  logic [width-1:0]      mem_rd,
  output logic [addr_width+1:0] count
);

  localparam logic [addr_width-1:0] LAST_PTR   = addr_width'(depth - 1);
  localparam logic [addr_width:0]   DEPTH_USED = (addr_width + 1)'(depth);

  logic [addr_width-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [addr_width:0]   used_q, used_d, avail_q, avail_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [width-1:0]      buf0_q, buf0_d, buf1_q, buf1_d;
  logic [addr_width+1:0] count_q, count_d;
  logic                  push, pop, elig;
  logic [2:0]            buf_room;

  assign i_r      = !reset && (used_q < DEPTH_USED);
  assign push     = i_v && i_r;
  assign o_v      = !reset && (buf_cnt_q != 2'd0);
  assign pop      = o_v && o_r;
  assign buf_room = {1'b0, buf_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign mem_re   = !reset && (avail_q != '0) && (buf_room < 3'd2);

  assign mem_we = push;
  assign mem_wa = wptr_q;
  assign mem_wd = i_d;
  assign mem_ra = rptr_q;
  assign o_d    = buf0_q;
  assign count  = reset ? '0 : count_q;

  // An accepted word only becomes readable once the memory write path has
  // caught up, so accept events are delayed before they count as available.
  if (wdelay == 0) begin : g_nodelay
    assign elig = push;
  end else begin : g_delay
    logic [wdelay-1:0] acc_q, acc_d;
    always_comb begin
      acc_d    = acc_q << 1;
      acc_d[0] = push;
    end
    always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
    end
    assign elig = acc_q[wdelay-1];
  end

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    used_d     = used_q + (addr_width + 1)'(push) - (addr_width + 1)'(mem_re);
    avail_d    = avail_q + (addr_width + 1)'(elig) - (addr_width + 1)'(mem_re);
    inflight_d = mem_re;
    count_d    = count_q + (addr_width + 2)'(push) - (addr_width + 2)'(pop);
    if (push) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    if (mem_re) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
  end

  // Pop shifts the tail into the head first, then returning read data fills
  // the first free slot; mem_re gating guarantees a free slot exists.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      buf0_d    = buf1_q;
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (inflight_q) begin
      if (buf_cnt_d == 2'd0) buf0_d = mem_rd;
      else                   buf1_d = mem_rd;
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      used_q     <= '0;
      avail_q    <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      count_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      used_q     <= used_d;
      avail_q    <= avail_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      count_q    <= count_d;
    end
  end

  // NOTE: buffer data carries no reset; buf_cnt_q alone decides validity, and
  // clearing inflight_q on reset drops any stale mem_rd still returning.
  always_ff @(posedge clk) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

endmodule

// File: tb/tb_base_mem_fifo_ctl.sv
// Scoreboard bench for base_mem_fifo_ctl: accepted words are queued, a
// monitor pops and compares every delivered word, directed tests add timing.
module tb_base_mem_fifo_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       i_v, i_r, o_v, o_r, mem_we, mem_re;
  logic [7:0] i_d, o_d, mem_wd, mem_rd;
  logic [1:0] mem_wa, mem_ra;
  logic [3:0] count;

  logic       i_v2, i_r2, o_v2, o_r2, mem_we2, mem_re2;
  logic [7:0] i_d2, o_d2, mem_wd2, mem_rd2;
  logic [1:0] mem_wa2, mem_ra2;
  logic [3:0] count2;

  base_mem_fifo_ctl #(.width(8), .addr_width(2), .depth(4), .wdelay(0)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .mem_we(mem_we), .mem_wa(mem_wa),
    .mem_wd(mem_wd), .mem_re(mem_re), .mem_ra(mem_ra), .mem_rd(mem_rd),
    .count(count)
  );

  base_mem_fifo_ctl #(.width(8), .addr_width(2), .depth(4), .wdelay(2)) dut2 (
    .clk(clk), .reset(reset), .i_v(i_v2), .i_r(i_r2), .i_d(i_d2),
    .o_v(o_v2), .o_r(o_r2), .o_d(o_d2), .mem_we(mem_we2), .mem_wa(mem_wa2),
    .mem_wd(mem_wd2), .mem_re(mem_re2), .mem_ra(mem_ra2), .mem_rd(mem_rd2),
    .count(count2)
  );

  // Memory models: registered read; the second one delays writes by 2 cycles.
  logic [7:0] ram0 [4];
  always @(posedge clk) begin
    if (mem_we) ram0[mem_wa] <= mem_wd;
    if (mem_re) mem_rd <= ram0[mem_ra];
  end

  logic [7:0] ram2 [4];
  logic       we_p1, we_p2;
  logic [1:0] wa_p1, wa_p2;
  logic [7:0] wd_p1, wd_p2;
  always @(posedge clk) begin
    we_p1 <= mem_we2; wa_p1 <= mem_wa2; wd_p1 <= mem_wd2;
    we_p2 <= we_p1;   wa_p2 <= wa_p1;   wd_p2 <= wd_p1;
    if (we_p2) ram2[wa_p2] <= wd_p2;
    if (mem_re2) mem_rd2 <= ram2[mem_ra2];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  int         pops = 0;
  logic [1:0] wexp, rexp;

  // Stimulus side of the scoreboard: record each accepted word and the
  // address order the memory must see.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      wexp = 2'd0;
      rexp = 2'd0;
    end else begin
      if (i_v && i_r) begin
        exp_q.push_back(i_d);
        check("mem_we", mem_we, 1);
        check("mem_wa", mem_wa, wexp);
        check("mem_wd", mem_wd, i_d);
        wexp = wexp + 2'd1;
      end
      if (mem_re) begin
        check("mem_ra", mem_ra, rexp);
        rexp = rexp + 2'd1;
      end
    end
  end

  // Monitor: compare every delivered word and check hold stability.
  logic       hold_prev = 1'b0;
  logic [7:0] hold_d;
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_o_v", o_v, 1);
        check("hold_o_d", o_d, hold_d);
      end
      if (o_v && o_r) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_extra: got word %0h with nothing expected", o_d);
        end else begin
          check("out_data", o_d, exp_q.pop_front());
        end
      end
      hold_prev = o_v && !o_r;
      hold_d    = o_d;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  int ov_t  [5] = '{0, 0, 0, 1, 0};
  int cnt_t [5] = '{0, 1, 1, 1, 0};

  initial begin
    int idx, first_ov, gap, outs, maxc, pops0, re_cyc, ov_cyc;
    logic [7:0] ov_d;
    reset = 1'b1; i_v = 1'b1; i_d = 8'h77; o_r = 1'b0;
    i_v2 = 1'b0; i_d2 = 8'h00; o_r2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_i_r", i_r, 0);
    check("rst_o_v", o_v, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_count", count, 0);
    @(posedge clk); #1;
    reset = 1'b0; i_v = 1'b0;
    @(negedge clk);
    check("post_rst_i_r", i_r, 1);

    // Single word latency
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      i_v = (c == 0); i_d = 8'hA5; o_r = 1'b1;
      @(negedge clk);
      check($sformatf("single_o_v_c%0d", c), o_v, ov_t[c]);
      check($sformatf("single_count_c%0d", c), count, cnt_t[c]);
      if (c == 3) check("single_o_d", o_d, 8'hA5);
    end

    // Fill with the output stalled: capacity is depth+2
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      i_v = (idx < 8); i_d = 8'(idx); o_r = 1'b0;
      @(negedge clk);
      if (i_v && i_r) idx++;
    end
    check("fill_accepted", idx, 6);
    check("fill_i_r", i_r, 0);
    check("fill_count", count, 6);
    pops0 = pops;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      i_v = 1'b0; o_r = 1'b1;
      @(negedge clk);
    end
    check("fill_drain_left", exp_q.size(), 0);
    check("fill_drain_pops", pops - pops0, 6);

    // Full-rate stream
    repeat (2) @(posedge clk);
    idx = 0; first_ov = -1; gap = 0; outs = 0; maxc = 0;
    for (int c = 0; c < 60 && outs < 20; c++) begin
      @(posedge clk); #1;
      i_v = (idx < 20); i_d = 8'(idx); o_r = 1'b1;
      @(negedge clk);
      if (i_v && i_r) idx++;
      if (o_v) begin
        if (first_ov < 0) first_ov = c;
        outs++;
      end else if (first_ov >= 0) begin
        gap++;
      end
      if (int'(count) > maxc) maxc = int'(count);
    end
    check("stream_first_o_v", first_ov, 3);
    check("stream_gaps", gap, 0);
    check("stream_outs", outs, 20);
    check("stream_count_le3", (maxc <= 3), 1);

    // Random valid/ready traffic
    @(posedge clk); #1;
    i_v = 1'b0;
    idx = 0; maxc = 0;
    for (int c = 0; c < 3000 && idx < 200; c++) begin
      @(posedge clk); #1;
      i_v = (idx < 200) && ($urandom_range(0, 1) == 1);
      i_d = 8'($urandom);
      o_r = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (i_v && i_r) idx++;
      if (int'(count) > maxc) maxc = int'(count);
    end
    check("rand_sent", idx, 200);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      i_v = 1'b0; o_r = 1'b1;
      @(negedge clk);
    end
    check("rand_drain_left", exp_q.size(), 0);
    check("rand_count_le6", (maxc <= 6), 1);

    // Reset mid-operation with a read in flight
    repeat (2) @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      i_v = 1'b1; i_d = 8'(8'h11 + c); o_r = 1'b0;
      @(negedge clk);
      if (c == 2) check("midrst_mem_re", mem_re, 1);
    end
    @(posedge clk); #1;
    check("midrst_count_before", count, 3);
    reset = 1'b1; i_v = 1'b0;
    @(negedge clk);
    check("midrst_o_v_in_rst", o_v, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_o_v", o_v, 0);
    check("midrst_count", count, 0);
    check("midrst_i_r", i_r, 1);
    @(posedge clk); #1;
    i_v = 1'b1; i_d = 8'h3C; o_r = 1'b1;
    @(negedge clk);
    ov_cyc = -1; ov_d = 8'h00;
    for (int c = 1; c < 12 && ov_cyc < 0; c++) begin
      @(posedge clk); #1;
      i_v = 1'b0;
      @(negedge clk);
      if (o_v) begin ov_cyc = c; ov_d = o_d; end
    end
    check("midrst_first_cycle", ov_cyc, 3);
    check("midrst_first_word", ov_d, 8'h3C);

    // Write-path delay of 2 on the second instance
    re_cyc = -1; ov_cyc = -1; ov_d = 8'h00;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      i_v2 = (c == 0); i_d2 = 8'h5A;
      @(negedge clk);
      if (c == 0) check("wd2_i_r", i_r2, 1);
      if (mem_re2 && re_cyc < 0) re_cyc = c;
      if (o_v2 && ov_cyc < 0) begin ov_cyc = c; ov_d = o_d2; end
    end
    check("wd2_mem_re_cycle", re_cyc, 3);
    check("wd2_o_v_cycle", ov_cyc, 5);
    check("wd2_o_d", ov_d, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
